// File: rtl/four_digit_scanner_if.sv
// Signal bundle between a host and the four-digit display scanner.
// The host uses the master side and the scanner uses the slave side.
interface four_digit_scanner_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  char;
    logic [3:0]  anode;
    logic        dp;
    logic        busy;
    logic        frame_tick;

    modport master (
        output data_in, dp_in, load, lz_en,
        input  char, anode, dp, busy, frame_tick
    );

    modport slave (
        input  data_in, dp_in, load, lz_en,
        output char, anode, dp, busy, frame_tick
    );
endinterface

// File: rtl/four_digit_scanner.sv
// Time-multiplexed four-digit 7-segment scanner with a blanking guard per slot.
// New values are double-buffered and only go live on a frame boundary.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | leading guard cycles of a slot, all anodes off, dp off
// ST_SHOW  | rest of the slot, anode of digit idx on (unless suppressed)
module four_digit_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    four_digit_scanner_if.slave  bus
);
    localparam logic [15:0] CNT_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYCLES);

    typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic [15:0] r_active;
    logic [15:0] r_shadow;
    logic [3:0]  r_active_dp;
    logic [3:0]  r_shadow_dp;
    logic        r_pending;
    logic        r_frame_tick;
    logic        r_lz;
    logic        w_boundary;
    logic [3:0]  w_suppress;
    logic [3:0]  w_anode;
    logic        w_dp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= 16'd0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt   = r_cnt + 16'd1;
        w_idx_nxt   = r_idx;
        w_anode     = 4'hF;
        w_dp        = 1'b1;
        w_boundary  = (r_idx == 2'd3) && (r_cnt == CNT_LAST);
        if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = 16'd0;
            w_idx_nxt = r_idx + 2'd1;
        end
        // State follows the counter value it will hold after this edge.
        w_state_nxt = (w_cnt_nxt < BLANK_END) ? ST_BLANK : ST_SHOW;
        case (r_state)
            ST_SHOW: begin
                if (!w_suppress[r_idx]) begin
                    w_anode = ~(4'b0001 << r_idx);
                end
                w_dp = ~r_active_dp[r_idx];
            end
            default: begin
                w_anode = 4'hF;
                w_dp    = 1'b1;
            end
        endcase
    end

    // A digit with its own dp lit is never blanked, even if it and all higher digits are zero.
    assign w_suppress[0] = 1'b0;
    assign w_suppress[1] = r_lz && (r_active[15:4]  == 12'h000) && !r_active_dp[1];
    assign w_suppress[2] = r_lz && (r_active[15:8]  == 8'h00)   && !r_active_dp[2];
    assign w_suppress[3] = r_lz && (r_active[15:12] == 4'h0)    && !r_active_dp[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active     <= 16'h0000;
            r_active_dp  <= 4'h0;
            r_shadow     <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_lz         <= 1'b0;
        end else begin
            r_lz         <= bus.lz_en;
            r_frame_tick <= w_boundary;
            if (w_boundary && r_pending) begin
                r_active    <= r_shadow;
                r_active_dp <= r_shadow_dp;
            end
            // A load on the boundary edge lands in the shadow after the old shadow went live.
            if (bus.load) begin
                r_shadow    <= bus.data_in;
                r_shadow_dp <= bus.dp_in;
                r_pending   <= 1'b1;
            end else if (w_boundary) begin
                r_pending   <= 1'b0;
            end
        end
    end

    assign bus.anode      = w_anode;
    assign bus.dp         = w_dp;
    assign bus.char       = r_active[{r_idx, 2'b00} +: 4];
    assign bus.busy       = r_pending;
    assign bus.frame_tick = r_frame_tick;
endmodule
